// File: rtl/maze_lookup_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// maze_lookup_arbiter_pkg
// Shared constants and types for the maze lookup arbiter slice.
//   - Maze geometry (MAZE_W, MAZE_H) and coordinate widths (X_W, Y_W).
//   - Requester count and IDs (0 = pacman, 1..4 = ghosts).
//   - Memory latency of the maze ROM.
//   - tag_t: bookkeeping carried alongside each lookup until its response.
//   - idToOnehot: converts a requester ID into a one-hot requester vector.
// ---------------------------------------------------------------------------
package maze_lookup_arbiter_pkg;

    localparam int N_REQ   = 5;
    localparam int X_W     = 10;
    localparam int Y_W     = 10;
    localparam int MEM_LAT = 2;
    localparam int ID_W    = 3;

    localparam logic [X_W-1:0] MAZE_W = 10'd640;
    localparam logic [Y_W-1:0] MAZE_H = 10'd480;

    typedef enum logic [ID_W-1:0] {
        REQ_PAC    = 3'd0,
        REQ_GHOST0 = 3'd1,
        REQ_GHOST1 = 3'd2,
        REQ_GHOST2 = 3'd3,
        REQ_GHOST3 = 3'd4
    } req_id_e;

    // One entry per lookup in flight; oob marks lookups that never touched the ROM.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            oob;
    } tag_t;

    function automatic logic [N_REQ-1:0] idToOnehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (id == ID_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/maze_lookup_arbiter_if.sv
// ---------------------------------------------------------------------------
// maze_lookup_arbiter_if
// Bundles the requester-side handshake and the maze ROM port of the arbiter.
//   hold                  : freeze new grants (game WIN/LOSE)
//   req/req_x/req_y       : per-requester level request and packed coordinates
//   gnt                   : one-hot accept pulse
//   rsp_valid/wall/inter  : one-hot response pulse plus lookup result
//   mem_rd/mem_x/mem_y    : ROM read strobe and address
//   mem_wall/mem_inter    : ROM data, MEM_LAT cycles after mem_rd
//   busy                  : any lookup in flight
// Modports: slave = arbiter, master = movers/ROM/testbench side.
// ---------------------------------------------------------------------------
interface maze_lookup_arbiter_if;
    import maze_lookup_arbiter_pkg::*;

    logic                 hold;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*X_W-1:0] req_x;
    logic [N_REQ*Y_W-1:0] req_y;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     rsp_valid;
    logic                 rsp_wall;
    logic                 rsp_inter;
    logic                 mem_rd;
    logic [X_W-1:0]       mem_x;
    logic [Y_W-1:0]       mem_y;
    logic                 mem_wall;
    logic                 mem_inter;
    logic                 busy;

    modport slave (
        input  hold, req, req_x, req_y, mem_wall, mem_inter,
        output gnt, rsp_valid, rsp_wall, rsp_inter, mem_rd, mem_x, mem_y, busy
    );

    modport master (
        output hold, req, req_x, req_y, mem_wall, mem_inter,
        input  gnt, rsp_valid, rsp_wall, rsp_inter, mem_rd, mem_x, mem_y, busy
    );

endinterface

// File: rtl/maze_lookup_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req_i   : eligible requests (already masked by hold)
//   ptr_i   : highest-priority index this cycle
//   gnt_o   : one-hot winner (all zero when nothing eligible)
//   idx_o   : winner index
//   valid_o : a winner exists
// ---------------------------------------------------------------------------
module rr_pick
    import maze_lookup_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

    logic [ID_W:0]   cand;
    logic            found;
    logic [ID_W-1:0] foundIdx;

    // Walk the requesters starting at ptr, wrapping modulo N_REQ; first hit wins.
    always_comb begin
        cand     = '0;
        found    = 1'b0;
        foundIdx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = {1'b0, ptr_i} + (ID_W+1)'(off);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found    = 1'b1;
                foundIdx = cand[ID_W-1:0];
            end
        end
    end

    assign valid_o = found;
    assign idx_o   = foundIdx;
    assign gnt_o   = idToOnehot(foundIdx) & {N_REQ{found}};

endmodule

// File: rtl/maze_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// maze_lookup_arbiter
// Shares the single maze ROM lookup port between pacman and the four ghosts.
// One round-robin grant per cycle; lookups are fully pipelined over MEM_LAT
// and responses return to the issuer in issue order.
//   clk     : system clock
//   reset_n : synchronous active-low reset, discards everything in flight
//   bus     : requester handshake + ROM port (see maze_lookup_arbiter_if)
// ---------------------------------------------------------------------------
module maze_lookup_arbiter
    import maze_lookup_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    maze_lookup_arbiter_if.slave  bus
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [X_W-1:0]   reqX [N_REQ];
    logic [Y_W-1:0]   reqY [N_REQ];
    logic [N_REQ-1:0] pickGnt;
    logic [ID_W-1:0]  pickIdx;
    logic             pickValid;
    logic [X_W-1:0]   selX;
    logic [Y_W-1:0]   selY;
    logic             selOob;

    logic [ID_W-1:0]  ptr_q,       ptr_d;
    logic [N_REQ-1:0] gnt_q,       gnt_d;
    logic             mem_rd_q,    mem_rd_d;
    logic [X_W-1:0]   mem_x_q,     mem_x_d;
    logic [Y_W-1:0]   mem_y_q,     mem_y_d;
    tag_t             tag_d;
    tag_t             tag_q [MEM_LAT+1];
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic             rsp_wall_q,  rsp_wall_d;
    logic             rsp_inter_q, rsp_inter_d;
    logic             busyOr;

    // Unpack the flat coordinate buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            reqX[i] = bus.req_x[i*X_W +: X_W];
            reqY[i] = bus.req_y[i*Y_W +: Y_W];
        end
    end

    rr_pick u_pick (
        .req_i   (bus.req & {N_REQ{~bus.hold}}),
        .ptr_i   (ptr_q),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    assign selX   = reqX[pickIdx];
    assign selY   = reqY[pickIdx];
    assign selOob = (selX >= MAZE_W) || (selY >= MAZE_H);

    // Issue stage: a winner is registered together with its ROM address and tag.
    // Out-of-bounds lookups still take a tag slot so ordering stays intact.
    always_comb begin
        ptr_d    = ptr_q;
        gnt_d    = '0;
        mem_rd_d = 1'b0;
        mem_x_d  = mem_x_q;
        mem_y_d  = mem_y_q;
        tag_d    = '0;
        if (pickValid) begin
            gnt_d    = pickGnt;
            ptr_d    = (pickIdx == LAST_ID) ? '0 : pickIdx + ID_W'(1);
            mem_rd_d = ~selOob;
            mem_x_d  = selX;
            mem_y_d  = selY;
            tag_d    = '{valid: 1'b1, id: pickIdx, oob: selOob};
        end
    end

    // Response stage: the oldest tag meets the ROM data; results hold between pulses.
    always_comb begin
        rsp_valid_d = '0;
        rsp_wall_d  = rsp_wall_q;
        rsp_inter_d = rsp_inter_q;
        if (tag_q[MEM_LAT].valid) begin
            rsp_valid_d = idToOnehot(tag_q[MEM_LAT].id);
            rsp_wall_d  = tag_q[MEM_LAT].oob ? 1'b1 : bus.mem_wall;
            rsp_inter_d = tag_q[MEM_LAT].oob ? 1'b0 : bus.mem_inter;
        end
    end

    // All state, including the tag pipe, clears on reset so nothing issued before
    // reset can produce a response afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
            rsp_valid_q <= '0;
            rsp_wall_q  <= 1'b0;
            rsp_inter_q <= 1'b0;
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_x_q     <= mem_x_d;
            mem_y_q     <= mem_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wall_q  <= rsp_wall_d;
            rsp_inter_q <= rsp_inter_d;
            tag_q[0]    <= tag_d;
            for (int k = 1; k <= MEM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        busyOr = 1'b0;
        for (int k = 0; k <= MEM_LAT; k++) begin
            busyOr = busyOr | tag_q[k].valid;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_x     = mem_x_q;
    assign bus.mem_y     = mem_y_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wall  = rsp_wall_q;
    assign bus.rsp_inter = rsp_inter_q;
    assign bus.busy      = busyOr;

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// tb_maze_lookup_arbiter
// Directed bench for maze_lookup_arbiter. Grants are checked inline as they
// happen; each accepted lookup pushes its hand-computed response into a queue
// that an independent monitor drains whenever rsp_valid is seen.
// ROM model: wall = x[0]^y[0], inter = x[3]^y[2], returned MEM_LAT cycles
// after mem_rd; idle cycles drive wall=0/inter=1.
// ---------------------------------------------------------------------------
module tb_maze_lookup_arbiter;
    import maze_lookup_arbiter_pkg::*;

    localparam int RSP_DELAY = MEM_LAT + 1;

    typedef struct {
        int   id;
        logic wall;
        logic inter;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    // Hand-computed coordinates and ROM results per requester.
    int   coordX   [N_REQ] = '{8, 1, 3, 2, 8};
    int   coordY   [N_REQ] = '{8, 0, 5, 2, 1};
    logic expWall  [N_REQ] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic expInter [N_REQ] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    maze_lookup_arbiter_if bus ();

    maze_lookup_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // ROM model: two-deep capture pipe sampled on the falling edge.
    logic           d1Rd = 1'b0, d2Rd = 1'b0;
    logic [X_W-1:0] d1X = '0, d2X = '0;
    logic [Y_W-1:0] d1Y = '0, d2Y = '0;

    initial begin
        bus.mem_wall  = 1'b0;
        bus.mem_inter = 1'b1;
    end

    always @(negedge clk) begin
        d1Rd <= bus.mem_rd;
        d1X  <= bus.mem_x;
        d1Y  <= bus.mem_y;
        d2Rd <= d1Rd;
        d2X  <= d1X;
        d2Y  <= d1Y;
        if (d2Rd) begin
            bus.mem_wall  <= d2X[0] ^ d2Y[0];
            bus.mem_inter <= d2X[3] ^ d2Y[2];
        end else begin
            bus.mem_wall  <= 1'b0;
            bus.mem_inter <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid !== '0) begin
            if (expQ.size() == 0) begin
                checkOutput("rspUnexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspId",    32'(bus.rsp_valid), 32'd1 << e.id);
                checkOutput("rspWall",  32'(bus.rsp_wall),  32'(e.wall));
                checkOutput("rspInter", 32'(bus.rsp_inter), 32'(e.inter));
                checkOutput("rspCycle", 32'(cycle),         32'(e.due));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] reqMask, input logic holdVal);
        bus.req  = reqMask;
        bus.hold = holdVal;
    endtask

    task automatic setCoord(input int i, input int x, input int y);
        bus.req_x[i*X_W +: X_W] = X_W'(x);
        bus.req_y[i*Y_W +: Y_W] = Y_W'(y);
    endtask

    task automatic loadCoords();
        for (int i = 0; i < N_REQ; i++) begin
            setCoord(i, coordX[i], coordY[i]);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic checkGrant(input string name, input int id, input int x, input int y,
                              input bit rd, input bit wall, input bit inter, input bit push);
        exp_t e;
        checkOutput({name, "_gnt"},   32'(bus.gnt),    32'd1 << id);
        checkOutput({name, "_memRd"}, 32'(bus.mem_rd), 32'(rd));
        if (rd) begin
            checkOutput({name, "_memX"}, 32'(bus.mem_x), 32'(x));
            checkOutput({name, "_memY"}, 32'(bus.mem_y), 32'(y));
        end
        if (push) begin
            e.id    = id;
            e.wall  = wall;
            e.inter = inter;
            e.due   = cycle + RSP_DELAY;
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            step();
        end
        checkOutput({name, "_drain"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req   = '0;
        bus.hold  = 1'b0;
        bus.req_x = '0;
        bus.req_y = '0;
        loadCoords();

        // Reset held with every requester asking.
        reset_n = 1'b0;
        applyStimulus(5'b11111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("reset_gnt",      32'(bus.gnt),       32'd0);
            checkOutput("reset_memRd",    32'(bus.mem_rd),    32'd0);
            checkOutput("reset_busy",     32'(bus.busy),      32'd0);
            checkOutput("reset_rspValid", 32'(bus.rsp_valid), 32'd0);
            checkOutput("reset_rspWall",  32'(bus.rsp_wall),  32'd0);
            checkOutput("reset_memX",     32'(bus.mem_x),     32'd0);
        end

        // Single lookup from pacman.
        reset_n = 1'b1;
        applyStimulus(5'b00001, 1'b0);
        step();
        checkGrant("single", 0, 8, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("single_busy", 32'(bus.busy), 32'd1);
        applyStimulus(5'b00000, 1'b0);
        waitDrain("single");
        checkOutput("single_busyLow", 32'(bus.busy), 32'd0);

        // Round robin with everyone requesting continuously.
        doReset();
        applyStimulus(5'b11111, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            checkGrant("rr", k % N_REQ, coordX[k % N_REQ], coordY[k % N_REQ],
                       1'b1, expWall[k % N_REQ], expInter[k % N_REQ], 1'b1);
        end
        applyStimulus(5'b00000, 1'b0);
        waitDrain("rr");

        // Out-of-bounds x on ghost 1 (requester 2).
        setCoord(2, 640, 5);
        applyStimulus(5'b00100, 1'b0);
        step();
        checkGrant("oob", 2, 640, 5, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'b00000, 1'b0);
        waitDrain("oob");
        setCoord(2, 0, 700);
        applyStimulus(5'b00100, 1'b0);
        step();
        checkGrant("oobY", 2, 0, 700, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'b00000, 1'b0);
        waitDrain("oobY");
        loadCoords();

        // hold after two grants: in-flight lookups drain, no further grants.
        doReset();
        applyStimulus(5'b00011, 1'b0);
        step();
        checkGrant("hold", 0, 8, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        checkGrant("hold", 1, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'b00011, 1'b1);
        step();
        checkOutput("hold_noGnt",  32'(bus.gnt),  32'd0);
        checkOutput("hold_busyHi", 32'(bus.busy), 32'd1);
        step();
        checkOutput("hold_noGnt",  32'(bus.gnt),  32'd0);
        checkOutput("hold_busyHi", 32'(bus.busy), 32'd1);
        step();
        checkOutput("hold_noGnt",  32'(bus.gnt),  32'd0);
        checkOutput("hold_busyLow", 32'(bus.busy), 32'd0);
        checkOutput("hold_rspLeft", 32'(expQ.size()), 32'd0);
        waitDrain("hold");
        applyStimulus(5'b00000, 1'b0);

        // Reset with three lookups in flight; nothing may come back.
        doReset();
        applyStimulus(5'b00111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkGrant("flight", k, coordX[k], coordY[k], 1'b1, expWall[k], expInter[k], 1'b0);
        end
        applyStimulus(5'b00000, 1'b0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            checkOutput("flight_rspValid", 32'(bus.rsp_valid), 32'd0);
            checkOutput("flight_busy",     32'(bus.busy),      32'd0);
            step();
        end
        applyStimulus(5'b10100, 1'b0);
        step();
        checkGrant("restart", 2, coordX[2], coordY[2], 1'b1, expWall[2], expInter[2], 1'b1);
        applyStimulus(5'b00000, 1'b0);
        waitDrain("restart");

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
